button_event_arbiter: RTL and testbench

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

---
 rtl/doorlock_pkg.sv | 42 ++++
 rtl/button_event_arbiter_if.sv | 13 +
 rtl/event_fifo.sv | 41 ++++
 rtl/button_event_arbiter.sv | 95 +++++++++
 tb/tb_button_event_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/doorlock_pkg.sv
// Shared door-lock definitions: keypad event codes, default timing and the
// fixed arbitration order used when several key events are waiting.
`timescale 1ns / 1ps
package doorlock_pkg;

   localparam int LONG_PRESS_CYCLES_DEF = 64;
   localparam int MIN_PRESS_CYCLES_DEF  = 2;
   localparam int FIFO_DEPTH_DEF        = 4;
   localparam int NUM_DIGITS            = 10;
   localparam int NUM_KEYS              = 12;
   localparam int NUM_CODES             = 14;
   localparam int CODE_W                = 4;

   typedef enum logic [CODE_W-1:0] {
      EVT_DIGIT0        = 4'd0,
      EVT_DIGIT1        = 4'd1,
      EVT_DIGIT2        = 4'd2,
      EVT_DIGIT3        = 4'd3,
      EVT_DIGIT4        = 4'd4,
      EVT_DIGIT5        = 4'd5,
      EVT_DIGIT6        = 4'd6,
      EVT_DIGIT7        = 4'd7,
      EVT_DIGIT8        = 4'd8,
      EVT_DIGIT9        = 4'd9,
      EVT_CONFIRM_SHORT = 4'd10,
      EVT_CONFIRM_LONG  = 4'd11,
      EVT_SHUFFLE_SHORT = 4'd12,
      EVT_SHUFFLE_LONG  = 4'd13
   } evt_code_e;

   // Rank 0 is the most urgent event; digits follow in ascending order.
   function automatic logic [CODE_W-1:0] prio_code(input int rank);
      case (rank)
         0:       return EVT_CONFIRM_LONG;
         1:       return EVT_CONFIRM_SHORT;
         2:       return EVT_SHUFFLE_LONG;
         3:       return EVT_SHUFFLE_SHORT;
         default: return CODE_W'(rank - 4);
      endcase
   endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Event stream from the keypad arbiter to its consumer (valid/ready + sticky drop flag).
`timescale 1ns / 1ps
interface button_event_arbiter_if;
   import doorlock_pkg::*;

   logic              evt_valid;
   logic              evt_ready;
   logic [CODE_W-1:0] evt_code;
   logic              evt_dropped;

   modport master (output evt_valid, output evt_code, output evt_dropped, input evt_ready);
   modport slave  (input evt_valid, input evt_code, input evt_dropped, output evt_ready);
endinterface

// File: rtl/event_fifo.sv
// Registered event queue; pointers carry one extra wrap bit so full and empty differ.
`timescale 1ns / 1ps
module event_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             valid,
   input  logic             ready,
   output logic [WIDTH-1:0] dout
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_p0, rd_ptr_p0;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             pop;

   assign valid = (wr_ptr_p0 != rd_ptr_p0);
   assign full  = ((wr_ptr_p0 ^ rd_ptr_p0) == {1'b1, {AW{1'b0}}});
   assign pop   = valid && ready;
   // Gated so a stale slot never leaks onto the code bus when the queue is empty.
   assign dout  = valid ? mem[rd_ptr_p0[AW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_p0 <= '0;
         rd_ptr_p0 <= '0;
      end else begin
         if (push) wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
         if (pop)  rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_p0[AW-1:0]] <= din;
   end
endmodule

// File: rtl/button_event_arbiter.sv
// Keypad front end: per-key hold counters classify presses into event codes,
// pending bits collect them and a fixed-priority selector feeds the event queue.
`timescale 1ns / 1ps
module button_event_arbiter
   import doorlock_pkg::*;
#(
   parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF,
   parameter int MIN_PRESS_CYCLES  = MIN_PRESS_CYCLES_DEF,
   parameter int FIFO_DEPTH        = FIFO_DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [NUM_DIGITS-1:0]        digit_buttons,
   input  logic                         confirm_button,
   input  logic                         shuffle_button,
   button_event_arbiter_if.master       evt
);
   localparam int CNT_W = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PRESS_CYCLES);
   localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_PRESS_CYCLES);

   logic [NUM_KEYS-1:0]  keys;
   logic [CNT_W-1:0]     hold_cnt_p0 [NUM_KEYS];
   logic [NUM_KEYS-1:0]  armed_p0;
   logic [NUM_CODES-1:0] qual, pend_p1, grant_mask;
   logic                 dropped_p1;
   logic                 grant_vld, fifo_full, push;
   logic [CODE_W-1:0]    grant_code;

   assign keys = {shuffle_button, confirm_button, digit_buttons};

   // Stage 0 -> 1: classify presses from the counters as they stand before this edge.
   always_comb begin
      qual = '0;
      for (int k = 0; k < NUM_DIGITS; k++)
         qual[k] = armed_p0[k] && keys[k] && (hold_cnt_p0[k] == MIN_C - CNT_W'(1));
      for (int s = 0; s < 2; s++) begin
         qual[int'(EVT_CONFIRM_SHORT) + 2*s] = armed_p0[NUM_DIGITS+s] && !keys[NUM_DIGITS+s] &&
                                              (hold_cnt_p0[NUM_DIGITS+s] >= MIN_C) &&
                                              (hold_cnt_p0[NUM_DIGITS+s] <  LONG_C);
         qual[int'(EVT_CONFIRM_LONG) + 2*s]  = armed_p0[NUM_DIGITS+s] && keys[NUM_DIGITS+s] &&
                                              (hold_cnt_p0[NUM_DIGITS+s] == LONG_C - CNT_W'(1));
      end
   end

   // Scan from lowest to highest priority so the most urgent pending code wins.
   always_comb begin
      grant_vld  = 1'b0;
      grant_code = '0;
      for (int r = NUM_CODES - 1; r >= 0; r--) begin
         if (pend_p1[prio_code(r)]) begin
            grant_vld  = 1'b1;
            grant_code = prio_code(r);
         end
      end
   end

   assign push       = grant_vld && (!fifo_full || (evt.evt_valid && evt.evt_ready));
   assign grant_mask = push ? (NUM_CODES'(1) << grant_code) : '0;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int k = 0; k < NUM_KEYS; k++) hold_cnt_p0[k] <= '0;
         armed_p0   <= '0;
         pend_p1    <= '0;
         dropped_p1 <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            if (!keys[k])                    hold_cnt_p0[k] <= '0;
            else if (hold_cnt_p0[k] != LONG_C) hold_cnt_p0[k] <= hold_cnt_p0[k] + CNT_W'(1);
         end
         // A key that is already high when reset lifts stays ignored until it is let go.
         armed_p0 <= armed_p0 | ~keys;
         pend_p1  <= (pend_p1 & ~grant_mask) | (qual & ~pend_p1);
         if (|(qual & pend_p1)) dropped_p1 <= 1'b1;
      end
   end

   assign evt.evt_dropped = dropped_p1;

   // Stage 1 -> 2: registered queue toward the consumer.
   event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CODE_W)
   ) u_event_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .din   (grant_code),
      .full  (fifo_full),
      .valid (evt.evt_valid),
      .ready (evt.evt_ready),
      .dout  (evt.evt_code)
   );
endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: vector table, directed multi-cycle sequences and
// random stimulus compared every cycle against a queue-based reference model.
`timescale 1ns / 1ps
module tb_button_event_arbiter;
   localparam int LONG  = 64;
   localparam int MIN   = 2;
   localparam int DEPTH = 4;

   logic       clk;
   logic       rstn;
   logic [9:0] digit_buttons;
   logic       confirm_button;
   logic       shuffle_button;

   button_event_arbiter_if bus ();

   button_event_arbiter dut (
      .clk            (clk),
      .rstn           (rstn),
      .digit_buttons  (digit_buttons),
      .confirm_button (confirm_button),
      .shuffle_button (shuffle_button),
      .evt            (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int seen[$];

   // Reference model state: plain run lengths, pending flags and a code queue.
   int run_m[12];
   bit armed_m[12];
   bit pend_m[14];
   int q_m[$];
   bit drop_m;
   int prio_m[14] = '{11, 10, 13, 12, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit rst_n, input bit [11:0] k, input bit rdy);
      bit qv[14];
      bit was_pend[14];
      bit popped, can_push, done;
      if (!rst_n) begin
         for (int i = 0; i < 12; i++) begin run_m[i] = 0; armed_m[i] = 0; end
         for (int c = 0; c < 14; c++) pend_m[c] = 0;
         q_m.delete();
         drop_m = 0;
         return;
      end
      popped   = (q_m.size() > 0) && rdy;
      can_push = (q_m.size() < DEPTH) || popped;
      if (popped) void'(q_m.pop_front());
      for (int c = 0; c < 14; c++) begin qv[c] = 0; was_pend[c] = pend_m[c]; end
      for (int d = 0; d < 10; d++) qv[d] = k[d] && armed_m[d] && (run_m[d] + 1 == MIN);
      for (int s = 0; s < 2; s++) begin
         qv[10 + 2*s] = !k[10+s] && armed_m[10+s] && run_m[10+s] >= MIN && run_m[10+s] < LONG;
         qv[11 + 2*s] = k[10+s] && armed_m[10+s] && (run_m[10+s] + 1 == LONG);
      end
      done = 0;
      if (can_push)
         for (int r = 0; r < 14; r++)
            if (!done && pend_m[prio_m[r]]) begin
               q_m.push_back(prio_m[r]);
               pend_m[prio_m[r]] = 0;
               done = 1;
            end
      for (int c = 0; c < 14; c++)
         if (qv[c]) begin
            if (was_pend[c]) drop_m = 1;
            else pend_m[c] = 1;
         end
      for (int i = 0; i < 12; i++) begin
         run_m[i] = k[i] ? run_m[i] + 1 : 0;
         if (!k[i]) armed_m[i] = 1;
      end
   endtask

   task automatic cycle();
      if (bus.evt_valid && bus.evt_ready) seen.push_back(int'(bus.evt_code));
      @(posedge clk);
      model_step(rstn, {shuffle_button, confirm_button, digit_buttons}, bus.evt_ready);
      @(negedge clk);
      chk("model_valid",   int'(bus.evt_valid),   int'(q_m.size() > 0));
      chk("model_code",    int'(bus.evt_code),    (q_m.size() > 0) ? q_m[0] : 0);
      chk("model_dropped", int'(bus.evt_dropped), int'(drop_m));
   endtask

   task automatic press_digit(input int d);
      digit_buttons[d] = 1'b1;
      repeat (3) cycle();
      digit_buttons[d] = 1'b0;
      cycle();
   endtask

   typedef struct {
      logic       rstn;
      logic [9:0] dig;
      logic       conf;
      logic       shuf;
      logic       rdy;
      logic       ev;
      logic [3:0] ec;
      logic       ed;
   } vec_t;

   vec_t tbl[19];

   initial begin
      int long_at;
      int exp_c[5];
      bit rnd_rdy;

      tbl[0]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      tbl[1]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      tbl[2]  = '{1'b1, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      tbl[3]  = '{1'b1, 10'h040, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      tbl[4]  = '{1'b1, 10'h040, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      tbl[5]  = '{1'b1, 10'h040, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 1'b0};
      tbl[6]  = '{1'b1, 10'h040, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      tbl[7]  = '{1'b1, 10'h040, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      tbl[8]  = '{1'b1, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      tbl[9]  = '{1'b1, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      tbl[10] = '{1'b1, 10'h084, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      tbl[11] = '{1'b1, 10'h084, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      tbl[12] = '{1'b1, 10'h084, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0};
      tbl[13] = '{1'b1, 10'h084, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0};
      tbl[14] = '{1'b1, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      tbl[15] = '{1'b1, 10'h010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      tbl[16] = '{1'b1, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      tbl[17] = '{1'b1, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      tbl[18] = '{1'b1, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};

      rstn = 1'b0; digit_buttons = '0; confirm_button = 1'b0; shuffle_button = 1'b0;
      bus.evt_ready = 1'b1;

      // Reset, digit 6 hold, simultaneous digits 2/7 and a one-cycle glitch on 4.
      for (int i = 0; i < 19; i++) begin
         rstn = tbl[i].rstn; digit_buttons = tbl[i].dig;
         confirm_button = tbl[i].conf; shuffle_button = tbl[i].shuf;
         bus.evt_ready = tbl[i].rdy;
         cycle();
         chk($sformatf("tbl%0d_valid", i),   int'(bus.evt_valid),   int'(tbl[i].ev));
         chk($sformatf("tbl%0d_code", i),    int'(bus.evt_code),    int'(tbl[i].ec));
         chk($sformatf("tbl%0d_dropped", i), int'(bus.evt_dropped), int'(tbl[i].ed));
      end

      // Confirm short then long.
      seen.delete();
      confirm_button = 1'b1; repeat (27) cycle();
      confirm_button = 1'b0; repeat (4) cycle();
      chk("confirm_short_count", seen.size(), 1);
      chk("confirm_short_code", (seen.size() > 0) ? seen[0] : -1, 10);
      seen.delete();
      long_at = -1;
      confirm_button = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         cycle();
         if (long_at < 0 && bus.evt_valid) long_at = i;
      end
      confirm_button = 1'b0; repeat (5) cycle();
      chk("confirm_long_edge", long_at, 65);
      chk("confirm_long_count", seen.size(), 1);
      chk("confirm_long_code", (seen.size() > 0) ? seen[0] : -1, 11);

      // Backpressure: four queued, fifth held pending without loss.
      seen.delete();
      bus.evt_ready = 1'b0;
      for (int d = 0; d < 5; d++) press_digit(d);
      chk("bp_head_valid", int'(bus.evt_valid), 1);
      chk("bp_head_code", int'(bus.evt_code), 0);
      bus.evt_ready = 1'b1; repeat (8) cycle();
      chk("bp_count", seen.size(), 5);
      for (int i = 0; i < 5; i++) chk($sformatf("bp_order%0d", i), (seen.size() > i) ? seen[i] : -1, i);
      chk("bp_dropped", int'(bus.evt_dropped), 0);

      // Same digit qualifies twice while stuck pending.
      seen.delete();
      bus.evt_ready = 1'b0;
      for (int d = 0; d < 4; d++) press_digit(d);
      press_digit(5);
      press_digit(5);
      chk("drop_flag", int'(bus.evt_dropped), 1);
      bus.evt_ready = 1'b1; repeat (8) cycle();
      exp_c = '{0, 1, 2, 3, 5};
      chk("drop_count", seen.size(), 5);
      for (int i = 0; i < 5; i++) chk($sformatf("drop_order%0d", i), (seen.size() > i) ? seen[i] : -1, exp_c[i]);

      // Confirm held through reset stays masked until released.
      seen.delete();
      confirm_button = 1'b1; cycle();
      rstn = 1'b0;
      repeat (3) begin
         cycle();
         chk("rst_valid", int'(bus.evt_valid), 0);
         chk("rst_code", int'(bus.evt_code), 0);
         chk("rst_dropped", int'(bus.evt_dropped), 0);
      end
      rstn = 1'b1;
      repeat (80) cycle();
      confirm_button = 1'b0; repeat (3) cycle();
      chk("masked_count", seen.size(), 0);
      confirm_button = 1'b1; repeat (10) cycle();
      confirm_button = 1'b0; repeat (4) cycle();
      chk("fresh_count", seen.size(), 1);
      chk("fresh_code", (seen.size() > 0) ? seen[0] : -1, 10);

      // Random traffic against the reference model.
      rnd_rdy = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         for (int d = 0; d < 10; d++)
            if ($urandom_range(0, 5) == 0) digit_buttons[d] = ~digit_buttons[d];
         if ($urandom_range(0, 39) == 0) confirm_button = ~confirm_button;
         if ($urandom_range(0, 39) == 0) shuffle_button = ~shuffle_button;
         if ($urandom_range(0, 7) == 0) rnd_rdy = ~rnd_rdy;
         bus.evt_ready = rnd_rdy;
         rstn = ($urandom_range(0, 599) != 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
